// File: rtl/sobel_stream_ctrl_pkg.sv
// Shared Sobel definitions: pixel format, 3x3 window type and controller FSM states.
package sobel_stream_ctrl_pkg;

  localparam int PIXEL_WIDTH_OUT = 8;
  localparam int MAX_PIXEL_VAL   = 255;

  // One window row; pix0 is the left column.
  typedef struct packed {
    logic [PIXEL_WIDTH_OUT-1:0] pix0;
    logic [PIXEL_WIDTH_OUT-1:0] pix1;
    logic [PIXEL_WIDTH_OUT-1:0] pix2;
  } sobel_vector;

  // vector0 is the top row of the window.
  typedef struct packed {
    sobel_vector vector0;
    sobel_vector vector1;
    sobel_vector vector2;
  } sobel_matrix;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } sobel_ctrl_state_e;

endpackage

// File: rtl/sobel_core.sv
// Combinational Sobel magnitude |gx|+|gy| of a 3x3 window, saturated to the pixel range.
module sobel_core
  import sobel_stream_ctrl_pkg::*;
(
  input  sobel_matrix                matrix_i,
  output logic [PIXEL_WIDTH_OUT-1:0] sobel_pix_o
);

  function automatic logic signed [11:0] ext(input logic [PIXEL_WIDTH_OUT-1:0] p);
    return {4'b0000, p};
  endfunction

  logic signed [11:0] gx;
  logic signed [11:0] gy;
  logic [11:0]        ax;
  logic [11:0]        ay;
  logic [12:0]        mag;

  always_comb begin
    gx = (ext(matrix_i.vector0.pix2) + (ext(matrix_i.vector1.pix2) <<< 1) + ext(matrix_i.vector2.pix2))
       - (ext(matrix_i.vector0.pix0) + (ext(matrix_i.vector1.pix0) <<< 1) + ext(matrix_i.vector2.pix0));
    gy = (ext(matrix_i.vector2.pix0) + (ext(matrix_i.vector2.pix1) <<< 1) + ext(matrix_i.vector2.pix2))
       - (ext(matrix_i.vector0.pix0) + (ext(matrix_i.vector0.pix1) <<< 1) + ext(matrix_i.vector0.pix2));
    ax  = gx[11] ? 12'(-gx) : 12'(gx);
    ay  = gy[11] ? 12'(-gy) : 12'(gy);
    mag = {1'b0, ax} + {1'b0, ay};
    sobel_pix_o = (mag > 13'd255) ? 8'hFF : mag[7:0];
  end

endmodule

// File: rtl/sobel_stream_ctrl_line_buffer.sv
// One image row of pixel storage: clocked write, combinational read (old data on same-address write).
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Streams a raster frame through two line buffers and a 3x3 window into the Sobel core.
// Optional SOBEL_THRESHOLD_EN adds threshold_i and binarises the output stream.
module sobel_stream_ctrl
  import sobel_stream_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       start_i,
  input  logic [PIXEL_WIDTH_OUT-1:0] pix_i,
  input  logic                       pix_valid_i,
  output logic                       pix_ready_o,
  output sobel_matrix                matrix_o,
  input  logic [PIXEL_WIDTH_OUT-1:0] sobel_pix_i,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [PIXEL_WIDTH_OUT-1:0] threshold_i,
`endif
  output logic [PIXEL_WIDTH_OUT-1:0] out_pix_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       busy_o,
  output logic                       frame_done_o
);

  localparam int OUT_TOTAL = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
  localparam int COL_W     = $clog2(IMG_WIDTH);
  localparam int ROW_W     = $clog2(IMG_HEIGHT);
  localparam int CNT_W     = $clog2(OUT_TOTAL + 1);

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_ACTIVE = 2'(ACTIVE);
  localparam logic [1:0] ST_DONE   = 2'(DONE);

  logic [1:0]       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_done_q, in_done_d;
  logic             out_valid_q, out_valid_d;
  sobel_matrix      window_q, window_d;

  logic [PIXEL_WIDTH_OUT-1:0] lb0_rdata;
  logic [PIXEL_WIDTH_OUT-1:0] lb1_rdata;
  logic [PIXEL_WIDTH_OUT-1:0] result;
  logic accept, out_hs, arm, col_last, row_last;

  assign pix_ready_o = (state_q == ST_ACTIVE) & (~out_valid_q | out_ready_i) & ~in_done_q;
  assign accept      = pix_valid_i & pix_ready_o;
  assign out_hs      = out_valid_q & out_ready_i;
  assign col_last    = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last    = (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign arm         = accept & (row_q >= ROW_W'(2)) & (col_q >= COL_W'(2));

  // Line buffer 0 holds row r-1, line buffer 1 holds row r-2.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH_OUT)) u_lb0 (
    .clk_i (clk_i),
    .addr  (col_q),
    .we    (accept),
    .wdata (pix_i),
    .rdata (lb0_rdata)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH_OUT)) u_lb1 (
    .clk_i (clk_i),
    .addr  (col_q),
    .we    (accept),
    .wdata (lb0_rdata),
    .rdata (lb1_rdata)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    in_done_d   = in_done_q;
    out_valid_d = out_valid_q;
    window_d    = window_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_ACTIVE;
          col_d       = '0;
          row_d       = '0;
          cnt_d       = '0;
          in_done_d   = 1'b0;
          out_valid_d = 1'b0;
          window_d    = '0;
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          window_d.vector0.pix0 = window_q.vector0.pix1;
          window_d.vector0.pix1 = window_q.vector0.pix2;
          window_d.vector0.pix2 = lb1_rdata;
          window_d.vector1.pix0 = window_q.vector1.pix1;
          window_d.vector1.pix1 = window_q.vector1.pix2;
          window_d.vector1.pix2 = lb0_rdata;
          window_d.vector2.pix0 = window_q.vector2.pix1;
          window_d.vector2.pix1 = window_q.vector2.pix2;
          window_d.vector2.pix2 = pix_i;
          if (col_last) begin
            col_d = '0;
            if (row_last) in_done_d = 1'b1;
            else          row_d     = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
        if (arm)         out_valid_d = 1'b1;
        else if (out_hs) out_valid_d = 1'b0;
        if (out_hs) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(OUT_TOTAL - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      in_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      window_q    <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      in_done_q   <= in_done_d;
      out_valid_q <= out_valid_d;
      window_q    <= window_d;
    end
  end

`ifdef SOBEL_THRESHOLD_EN
  assign result = (sobel_pix_i >= threshold_i) ? PIXEL_WIDTH_OUT'(MAX_PIXEL_VAL - 1) : '0;
`else
  assign result = sobel_pix_i;
`endif

  // The window is frozen while an output waits, so the core result stays stable until taken.
  assign out_pix_o    = out_valid_q ? result : '0;
  assign out_valid_o  = out_valid_q;
  assign matrix_o     = window_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Randomised bench for sobel_stream_ctrl on a 5x4 frame, checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_sobel_stream_ctrl;

  localparam int W     = 5;
  localparam int H     = 4;
  localparam int N     = W * H;
  localparam int TOTAL = (W - 2) * (H - 2);
`ifdef SOBEL_THRESHOLD_EN
  localparam int EDGE_HI = 254;
`else
  localparam int EDGE_HI = 255;
`endif

  logic       clk = 1'b0;
  logic       nreset_i = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] pix_i = 8'd0;
  logic       pix_valid_i = 1'b0;
  logic       out_ready_i = 1'b1;
  logic       pix_ready_o;
  logic [7:0] out_pix_o;
  logic       out_valid_o;
  logic       busy_o;
  logic       frame_done_o;
  logic [7:0] sobel_pix;
  sobel_stream_ctrl_pkg::sobel_matrix matrix;
`ifdef SOBEL_THRESHOLD_EN
  logic [7:0] threshold_i = 8'd200;
`endif

  always #5 clk = ~clk;

  sobel_stream_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i        (clk),
    .nreset_i     (nreset_i),
    .start_i      (start_i),
    .pix_i        (pix_i),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .matrix_o     (matrix),
    .sobel_pix_i  (sobel_pix),
`ifdef SOBEL_THRESHOLD_EN
    .threshold_i  (threshold_i),
`endif
    .out_pix_o    (out_pix_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  sobel_core u_core (
    .matrix_i    (matrix),
    .sobel_pix_o (sobel_pix)
  );

  int errors = 0;
  int checks = 0;
  int img [N];
  int sob [TOTAL];
  int got [$];
  int done_cnt = 0;

  // Model state: 0 idle, 1 frame running, 2 done pulse.
  int m_state = 0;
  int m_in_idx = 0;
  int m_out_cnt = 0;
  bit m_pend = 1'b0;
  bit exp_ready, acc, hs, interior;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected output stream: Sobel magnitude of every interior pixel in raster order.
  function automatic void build_model();
    int gx, gy, v, p;
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        gx = 0;
        gy = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            p  = img[(r + dr) * W + (c + dc)];
            gx = gx + p * dc * ((dr == 0) ? 2 : 1);
            gy = gy + p * dr * ((dc == 0) ? 2 : 1);
          end
        end
        v = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        if (v > 255) v = 255;
`ifdef SOBEL_THRESHOLD_EN
        v = (v >= 200) ? 254 : 0;
`endif
        sob[(r - 1) * (W - 2) + (c - 1)] = v;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!nreset_i) begin
      m_state = 0;
      m_pend  = 1'b0;
      check("rst_pix_ready", int'(pix_ready_o), 0);
      check("rst_out_valid", int'(out_valid_o), 0);
      check("rst_out_pix", int'(out_pix_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_frame_done", int'(frame_done_o), 0);
    end else begin
      exp_ready = (m_state == 1) && !(m_pend && !out_ready_i) && (m_in_idx < N);
      check("pix_ready", int'(pix_ready_o), int'(exp_ready));
      check("out_valid", int'(out_valid_o), int'(m_pend));
      if (m_pend && m_out_cnt < TOTAL) check("out_pix", int'(out_pix_o), sob[m_out_cnt]);
      check("busy", int'(busy_o), int'(m_state != 0));
      check("frame_done", int'(frame_done_o), int'(m_state == 2));
      if (frame_done_o) done_cnt++;
      if (out_valid_o && out_ready_i) got.push_back(int'(out_pix_o));

      acc      = pix_valid_i && exp_ready;
      hs       = m_pend && out_ready_i;
      interior = acc && (m_in_idx / W >= 2) && (m_in_idx % W >= 2);
      case (m_state)
        0: if (start_i) begin
          m_state   = 1;
          m_in_idx  = 0;
          m_out_cnt = 0;
          m_pend    = 1'b0;
        end
        1: begin
          if (acc) m_in_idx++;
          if (hs) m_out_cnt++;
          if (interior)  m_pend = 1'b1;
          else if (hs)   m_pend = 1'b0;
          if (hs && m_out_cnt == TOTAL) m_state = 2;
        end
        default: m_state = 0;
      endcase
    end
  end

  task automatic run_frame(input string tag, input int vpct, input int rpct,
                           input int stall_at, input int rst_at, input int start_at);
    int cyc;
    int stall_n;
    bit sdone;
    stall_n = 0;
    sdone   = 1'b0;
    got.delete();
    done_cnt = 0;
    build_model();
    @(posedge clk); #1;
    start_i = 1'b1; pix_valid_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      if (m_state == 0) break;
      if (rst_at >= 0 && m_in_idx == rst_at) begin
        nreset_i = 1'b0;
        #1;
        check("async_rst_out_valid", int'(out_valid_o), 0);
        check("async_rst_pix_ready", int'(pix_ready_o), 0);
        check("async_rst_busy", int'(busy_o), 0);
        check("async_rst_out_pix", int'(out_pix_o), 0);
        @(posedge clk); #1;
        nreset_i = 1'b1;
        break;
      end
      pix_valid_i = ($urandom_range(99) < vpct);
      pix_i       = 8'(img[(m_in_idx < N) ? m_in_idx : N - 1]);
      if (stall_at >= 0 && m_in_idx >= stall_at && stall_n < 5) begin
        out_ready_i = 1'b0;
        stall_n++;
      end else begin
        out_ready_i = ($urandom_range(99) < rpct);
      end
      start_i = 1'b0;
      if (start_at >= 0 && m_in_idx == start_at && !sdone) begin
        start_i = 1'b1;
        sdone   = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (cyc >= 2000) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: %s did not finish within 2000 cycles", tag);
    end
    pix_valid_i = 1'b0;
    start_i     = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    $display("frame %s: outputs=%0d frame_done_pulses=%0d", tag, got.size(), done_cnt);
  endtask

  initial begin
    nreset_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nreset_i = 1'b1;

    for (int i = 0; i < N; i++) img[i] = 100;
    run_frame("flat", 100, 100, -1, -1, -1);
    check("flat_count", got.size(), 6);
    check("flat_done", done_cnt, 1);
    for (int i = 0; i < got.size(); i++) check("flat_value", got[i], 0);

    for (int i = 0; i < N; i++) img[i] = ((i % W) >= 2) ? 255 : 0;
    run_frame("edge", 100, 100, -1, -1, -1);
    check("edge_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) check("edge_value", got[i], ((i % 3) == 2) ? 0 : EDGE_HI);

    for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255));
    run_frame("backpressure", 100, 100, 13, -1, -1);
    check("bp_count", got.size(), 6);
    check("bp_done", done_cnt, 1);

    for (int i = 0; i < N; i++) img[i] = 100;
    run_frame("reset_mid", 100, 100, -1, 8, -1);
    check("reset_mid_done", done_cnt, 0);
    run_frame("after_reset", 100, 100, -1, -1, -1);
    check("after_reset_count", got.size(), 6);
    check("after_reset_done", done_cnt, 1);
    for (int i = 0; i < got.size(); i++) check("after_reset_value", got[i], 0);

    for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255));
    run_frame("start_in_active", 100, 100, -1, -1, 10);
    check("restart_count", got.size(), 6);
    check("restart_done", done_cnt, 1);

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++) img[i] = int'(((f % 2) == 0) ? $urandom_range(255) : $urandom_range(40));
      run_frame($sformatf("random%0d", f), int'($urandom_range(40, 100)), int'($urandom_range(40, 100)),
                -1, -1, -1);
      check("rand_count", got.size(), TOTAL);
      check("rand_done", done_cnt, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
